// File: rtl/turn_controller.sv
// Two-player turn sequencer with a per-turn countdown.
// A prescaler turns clock cycles into second ticks.
module turn_controller #(
  parameter int CLK_FREQ_HZ  = 50_000_000,
  parameter int TURN_SECONDS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       move_valid,
  input  logic       game_over,
  output logic       current_player,
  output logic       turn_active,
  output logic [3:0] seconds_left,
  output logic       timeout_pulse,
  output logic [3:0] turn_count
);

  localparam int PW = $clog2(CLK_FREQ_HZ);
  localparam logic [PW-1:0] P_MAX = PW'(CLK_FREQ_HZ - 1);
  localparam logic [3:0] SECS = 4'(TURN_SECONDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_TURN,
    S_SWITCH,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_state_nx;
  logic [PW-1:0] r_presc;
  logic [PW-1:0] w_presc_nx;
  logic          r_player;
  logic          w_player_nx;
  logic [3:0]    r_secs;
  logic [3:0]    w_secs_nx;
  logic [3:0]    r_count;
  logic [3:0]    w_count_nx;
  logic          r_tmo;
  logic          w_tmo_nx;
  logic          r_active;

  logic w_tick;
  logic w_end;
  logic w_move;
  logic w_expire;
  logic w_dec;

  // TURN exit events, priority-resolved so at most one is set
  assign w_tick   = (r_presc == P_MAX);
  assign w_end    = game_over;
  assign w_move   = !game_over && move_valid;
  assign w_expire = !game_over && !move_valid &&
                    w_tick && (r_secs == 4'd1);
  assign w_dec    = !game_over && !move_valid &&
                    w_tick && (r_secs != 4'd1);

  // Next-state and next-output decode
  always_comb begin
    w_state_nx  = r_state;
    w_presc_nx  = r_presc;
    w_player_nx = r_player;
    w_secs_nx   = r_secs;
    w_count_nx  = r_count;
    w_tmo_nx    = 1'b0;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nx  = S_TURN;
          w_player_nx = 1'b0;
          w_secs_nx   = SECS;
          w_count_nx  = 4'd0;
          w_presc_nx  = '0;
        end
      end
      S_TURN: begin
        w_presc_nx = w_tick ? '0 : r_presc + 1'b1;
        unique case (1'b1)
          w_end:  w_state_nx = S_DONE;
          w_move: w_state_nx = S_SWITCH;
          w_expire: begin
            w_state_nx = S_SWITCH;
            w_secs_nx  = 4'd0;
            w_tmo_nx   = 1'b1;
          end
          w_dec:  w_secs_nx = r_secs - 4'd1;
          default: ;
        endcase
      end
      S_SWITCH: begin
        if (game_over) begin
          w_state_nx = S_DONE;
        end else begin
          w_state_nx  = S_TURN;
          w_player_nx = !r_player;
          w_secs_nx   = SECS;
          w_presc_nx  = '0;
          if (r_count != 4'd15)
            w_count_nx = r_count + 4'd1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_presc  <= '0;
      r_player <= 1'b0;
      r_secs   <= 4'd0;
      r_count  <= 4'd0;
      r_tmo    <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_presc  <= w_presc_nx;
      r_player <= w_player_nx;
      r_secs   <= w_secs_nx;
      r_count  <= w_count_nx;
      r_tmo    <= w_tmo_nx;
      r_active <= (w_state_nx == S_TURN);
    end
  end

  assign current_player = r_player;
  assign turn_active    = r_active;
  assign seconds_left   = r_secs;
  assign timeout_pulse  = r_tmo;
  assign turn_count     = r_count;

endmodule

// File: tb/tb_turn_controller.sv
// Bench for turn_controller: elapsed-time model
// plus directed scenarios with literal checks.
module tb_turn_controller;

  localparam int F = 4;
  localparam int S = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       move_valid = 1'b0;
  logic       game_over = 1'b0;
  logic       current_player;
  logic       turn_active;
  logic [3:0] seconds_left;
  logic       timeout_pulse;
  logic [3:0] turn_count;

  int n_tests = 0;
  int n_fail  = 0;

  turn_controller #(
    .CLK_FREQ_HZ (F),
    .TURN_SECONDS(S)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .move_valid    (move_valid),
    .game_over     (game_over),
    .current_player(current_player),
    .turn_active   (turn_active),
    .seconds_left  (seconds_left),
    .timeout_pulse (timeout_pulse),
    .turn_count    (turn_count)
  );

  always #5 clk = ~clk;

  // Model: mode 0 idle, 1 in turn, 2 hand-over, 3 finished.
  // Seconds derive from cycles elapsed in the turn.
  int m_mode  = 0;
  int m_el    = 0;
  int m_secs  = 0;
  int m_cnt   = 0;
  bit m_pl    = 0;
  bit m_tmo   = 0;
  bit m_valid = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0; m_pl = 0; m_secs = 0;
      m_cnt = 0; m_tmo = 0; m_el = 0;
      m_valid = 1;
    end else begin
      m_tmo = 0;
      case (m_mode)
        0, 3: if (start) begin
          m_mode = 1; m_pl = 0; m_cnt = 0;
          m_el = 0; m_secs = S;
        end
        1: begin
          if (game_over) m_mode = 3;
          else if (move_valid) m_mode = 2;
          else if (m_el == S * F - 1) begin
            m_mode = 2; m_secs = 0; m_tmo = 1;
          end else begin
            m_el++;
            m_secs = S - m_el / F;
          end
        end
        2: begin
          if (game_over) m_mode = 3;
          else begin
            m_mode = 1;
            m_pl = !m_pl;
            m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
            m_el = 0;
            m_secs = S;
          end
        end
        default: ;
      endcase
    end
  end

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d @%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    if (m_valid) begin
      chk("m_player", int'(current_player), int'(m_pl));
      chk("m_active", int'(turn_active), int'(m_mode == 1));
      chk("m_secs", int'(seconds_left), m_secs);
      chk("m_tmo", int'(timeout_pulse), int'(m_tmo));
      chk("m_count", int'(turn_count), m_cnt);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      cmp_model();
    end
  endtask

  initial begin
    cyc(2);
    chk("rst_active", int'(turn_active), 0);
    chk("rst_secs", int'(seconds_left), 0);
    chk("rst_count", int'(turn_count), 0);
    rst = 1'b0;
    cyc(1);

    // uninterrupted turn, expiry
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk("t0_active", int'(turn_active), 1);
    chk("t0_secs", int'(seconds_left), 3);
    cyc(4);
    chk("t4_secs", int'(seconds_left), 2);
    cyc(4);
    chk("t8_secs", int'(seconds_left), 1);
    cyc(3);
    chk("t11_tmo", int'(timeout_pulse), 0);
    cyc(1);
    chk("exp_tmo", int'(timeout_pulse), 1);
    chk("exp_secs", int'(seconds_left), 0);
    chk("exp_active", int'(turn_active), 0);
    cyc(1);
    chk("exp_tmo_off", int'(timeout_pulse), 0);
    chk("exp_player", int'(current_player), 1);
    chk("exp_count", int'(turn_count), 1);
    chk("exp_reload", int'(seconds_left), 3);

    // move on turn cycle 5
    cyc(5);
    move_valid = 1'b1;
    cyc(1);
    move_valid = 1'b0;
    chk("mv_tmo", int'(timeout_pulse), 0);
    chk("mv_active", int'(turn_active), 0);
    chk("mv_secs", int'(seconds_left), 2);
    cyc(1);
    chk("mv_player", int'(current_player), 0);
    chk("mv_secs3", int'(seconds_left), 3);

    // move coincides with final tick
    cyc(11);
    move_valid = 1'b1;
    cyc(1);
    move_valid = 1'b0;
    chk("co_tmo", int'(timeout_pulse), 0);
    chk("co_secs", int'(seconds_left), 1);
    cyc(1);
    chk("co_player", int'(current_player), 1);
    chk("co_count", int'(turn_count), 3);

    // start ignored in TURN, then game over at cycle 6
    start = 1'b1;
    cyc(2);
    start = 1'b0;
    chk("st_ign_secs", int'(seconds_left), 3);
    cyc(4);
    game_over = 1'b1;
    cyc(1);
    chk("go_active", int'(turn_active), 0);
    chk("go_player", int'(current_player), 1);
    chk("go_secs", int'(seconds_left), 2);
    move_valid = 1'b1;
    cyc(3);
    move_valid = 1'b0;
    game_over = 1'b0;
    chk("go_hold", int'(current_player), 1);
    chk("go_hold_cnt", int'(turn_count), 3);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk("rs_player", int'(current_player), 0);
    chk("rs_count", int'(turn_count), 0);
    chk("rs_active", int'(turn_active), 1);

    // reset mid-turn
    cyc(4);
    chk("pre_rst_secs", int'(seconds_left), 2);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("mr_active", int'(turn_active), 0);
    chk("mr_secs", int'(seconds_left), 0);
    chk("mr_tmo", int'(timeout_pulse), 0);
    move_valid = 1'b1;
    game_over = 1'b1;
    cyc(2);
    move_valid = 1'b0;
    game_over = 1'b0;
    chk("idle_active", int'(turn_active), 0);
    chk("idle_count", int'(turn_count), 0);

    // 20 moves: saturation
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      move_valid = 1'b1;
      cyc(1);
      move_valid = 1'b0;
      cyc(1);
    end
    chk("sat_count", int'(turn_count), 15);
    chk("sat_player", int'(current_player), 0);

    // game over during hand-over
    move_valid = 1'b1;
    cyc(1);
    move_valid = 1'b0;
    game_over = 1'b1;
    cyc(1);
    game_over = 1'b0;
    chk("swgo_active", int'(turn_active), 0);
    chk("swgo_player", int'(current_player), 0);
    chk("swgo_count", int'(turn_count), 15);
    cyc(3);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
